// File: rtl/register_file_pkg.sv
// Shared types for the register file: clear-sweep FSM states and address-width helper.
package register_file_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic int rf_addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/register_file_rdport.sv
// One registered read port with zero-entry masking and optional write forwarding.
// Forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module register_file_rdport
  import register_file_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int AW        = 5,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wr_ok,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] rdata_next;

  // wr_ok already excludes dropped writes and the hard-wired zero entry.
  always_comb begin
    rdata_next = mem_data;
    if (ZERO_REG0 && raddr == '0) begin
      rdata_next = '0;
    end else if (BYPASS && wr_ok && waddr == raddr) begin
      rdata_next = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/register_file.sv
// Register file: one write port, two registered read ports, sequential clear sweep.
// Optional same-edge write forwarding via REGFILE_BYPASS_EN (see register_file_rdport).
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter bit ZERO_REG0 = 1'b1,
  localparam int AW       = rf_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr,
  output logic             busy,
  output logic             wr_drop
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  rf_state_t        state_reg;
  logic [AW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             wr_drop_reg;

  logic             zero_hit;
  logic             wr_ok;

  // Writes to the hard-wired zero entry vanish without counting as drops.
  assign zero_hit = ZERO_REG0 && (waddr == '0);
  assign wr_ok    = (state_reg == RF_IDLE) && we && !zero_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RF_IDLE;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      wr_drop_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      wr_drop_reg <= (state_reg == RF_CLEAR) && we && !zero_hit;
      case (state_reg)
        RF_IDLE: begin
          if (wr_ok) begin
            mem_reg[waddr] <= wdata;
          end
          if (clr) begin
            state_reg <= RF_CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        RF_CLEAR: begin
          mem_reg[cnt_reg] <= '0;
          cnt_reg          <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg <= RF_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= RF_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign wr_drop = wr_drop_reg;

  logic [AW-1:0]    raddr_arr [2];
  logic [WIDTH-1:0] rdata_arr [2];

  assign raddr_arr[0] = raddr_a;
  assign raddr_arr[1] = raddr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdport
    register_file_rdport #(
      .WIDTH     (WIDTH),
      .AW        (AW),
      .ZERO_REG0 (ZERO_REG0)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr    (raddr_arr[gi]),
      .mem_data (mem_reg[raddr_arr[gi]]),
      .wr_ok    (wr_ok),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata_arr[gi])
    );
  end

  assign rdata_a = rdata_arr[0];
  assign rdata_b = rdata_arr[1];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (32 x 32, ZERO_REG0=1).
// Expected forwarding behaviour follows REGFILE_BYPASS_EN.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        clr;
  logic        busy;
  logic        wr_drop;

  int checks = 0;
  int failures = 0;

  register_file #(
    .WIDTH     (32),
    .DEPTH     (32),
    .ZERO_REG0 (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b),
    .clr     (clr),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  int busy_cycles;
  logic [31:0] exp_fwd;

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr = 1'b0;

    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      tick();
      check($sformatf("post_rst_a[%0d]", i), rdata_a, 32'd0);
      check($sformatf("post_rst_b[%0d]", 31 - i), rdata_b, 32'd0);
    end

    write(5'd5, 32'h0000_1FFF);
    raddr_a = 5'd5;
    tick();
    check("rd_a_addr5", rdata_a, 32'h0000_1FFF);

    raddr_b = 5'd0;
    write(5'd0, 32'h001F_FF00);
    check("zero_wr_drop", {31'd0, wr_drop}, 32'd0);
    tick();
    check("zero_rd_b", rdata_b, 32'd0);

    write(5'd9, 32'h0000_1234);
    raddr_a = 5'd9;
    write(5'd9, 32'h07E0_0000);
`ifdef REGFILE_BYPASS_EN
    exp_fwd = 32'h07E0_0000;
`else
    exp_fwd = 32'h0000_1234;
`endif
    check("same_edge_a9", rdata_a, exp_fwd);
    tick();
    check("next_edge_a9", rdata_a, 32'h07E0_0000);

    for (int i = 0; i < 32; i++) begin
      write(5'(i), 32'hFFFF_FFFF);
    end
    raddr_a = 5'd1; raddr_b = 5'd0;
    tick();
    check("fill_a1", rdata_a, 32'hFFFF_FFFF);
    check("fill_b0", rdata_b, 32'd0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    raddr_a = 5'd31;
    busy_cycles = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      busy_cycles++;
      if (c == 9) begin we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA_5555; end
      if (c == 15) clr = 1'b1;
      tick();
      if (c == 5) check("sweep_read_uncleared", rdata_a, 32'hFFFF_FFFF);
      if (c == 9) begin check("sweep_wr_drop", {31'd0, wr_drop}, 32'd1); we = 1'b0; end
      if (c == 10) check("sweep_wr_drop_end", {31'd0, wr_drop}, 32'd0);
      if (c == 15) clr = 1'b0;
    end
    check("busy_cycles", 32'(busy_cycles), 32'd32);

    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      tick();
      check($sformatf("post_clr_a[%0d]", i), rdata_a, 32'd0);
    end

    write(5'd20, 32'h0000_0055);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("sweep7_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    raddr_a = 5'd20;
    tick();
    check("abort_rd20", rdata_a, 32'd0);
    write(5'd12, 32'h0000_CAFE);
    raddr_a = 5'd12;
    tick();
    check("abort_rd12", rdata_a, 32'h0000_CAFE);
    check("abort_busy_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
